integer_division: RTL

Sequential 32-bit integer divider producing quotient and remainder, one quotient bit per clock via restoring shift-subtract on operand magnitudes. It is the arithmetic inverse of the Booth-multiplier path in the Integer-Arithmetic unit. It sits beside the multiplier in the calculator datapath, with the same start/operand style, and adds an explicit done/busy handshake.

---
 rtl/int_arith_pkg.sv | 14 +
 rtl/addsub33.sv | 10 +
 rtl/integer_division.sv | 134 +++++++++++++
 3 files changed

// File: rtl/int_arith_pkg.sv
// Shared definitions for the integer-arithmetic unit: datapath width, divider FSM
// states, iteration counter width and the divide-by-zero quotient.
package int_arith_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUO = '1;
endpackage

// File: rtl/addsub33.sv
// 33-bit adder/subtractor with carry-out; with sub=1 a carry-out of 1 means a >= b.
module addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {33{sub}}} + {33'b0, sub};
endmodule

// File: rtl/integer_division.sv
// Sequential restoring divider, one quotient bit per clock, done/busy handshake.
// Signed operands when INTEGER_DIVISION_SIGNED_EN is defined, unsigned otherwise.
module integer_division
    import int_arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvs, dvd;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, add_a, add_b, add_sum;
    logic             add_cout;

    // {rem, quo} shifted left by one; the dividend bits stream out of quo into rem
    assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};

`ifdef INTEGER_DIVISION_SIGNED_EN
    logic           q_neg, r_neg;
    logic [WIDTH:0] rneg_sum;
    logic           rneg_cout;
    logic           unused_rneg;

    assign dvd_mag = dividend[WIDTH-1] ? WIDTH'(0) - dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? WIDTH'(0) - divisor  : divisor;

    // In FIX the trial adder is idle, so it negates the quotient magnitude
    always_comb begin
        add_a = rem_sh;
        add_b = {1'b0, dvs};
        if (state == FIX) begin
            add_a = '0;
            add_b = {1'b0, quo};
        end
    end

    addsub33 u_rneg (
        .a    ('0),
        .b    ({1'b0, rem[WIDTH-1:0]}),
        .sub  (1'b1),
        .sum  (rneg_sum),
        .cout (rneg_cout)
    );
    assign unused_rneg = &{1'b0, rneg_cout, rneg_sum[WIDTH]};
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign add_a   = rem_sh;
    assign add_b   = {1'b0, dvs};
`endif

    addsub33 u_trial (
        .a    (add_a),
        .b    (add_b),
        .sub  (1'b1),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            dvd       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
`ifdef INTEGER_DIVISION_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rem   <= '0;
                    quo   <= dvd_mag;
                    dvs   <= dvs_mag;
                    dvd   <= dividend;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
`ifdef INTEGER_DIVISION_SIGNED_EN
                    q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg <= dividend[WIDTH-1];
`endif
                end
                CALC: begin
                    // carry-out of the subtract means the trial remainder is non-negative
                    rem <= add_cout ? add_sum : rem_sh;
                    quo <= {quo[WIDTH-2:0], add_cout};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    if (dvs == '0) begin
                        quotient  <= DIV0_QUO;
                        remainder <= dvd;
                        div_zero  <= 1'b1;
                    end else begin
`ifdef INTEGER_DIVISION_SIGNED_EN
                        quotient  <= q_neg ? add_sum[WIDTH-1:0] : quo;
                        remainder <= r_neg ? rneg_sum[WIDTH-1:0] : rem[WIDTH-1:0];
`else
                        quotient  <= quo;
                        remainder <= rem[WIDTH-1:0];
`endif
                        div_zero  <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
